// File: rtl/ro_trng_pkg.sv
// rtl/ro_trng_pkg.sv - shared types and defaults for the ring-oscillator TRNG (controller and sampler)
package ro_trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } ro_state_e;

  localparam int DROP_CNT_W       = 8;
  localparam int RO_NUM_DEFAULT   = 32;
  localparam int RO_SEL_W_DEFAULT = 5;

endpackage

// File: rtl/ro_sync_bit.sv
// rtl/ro_sync_bit.sv - STAGES-deep single-bit synchronizer with synchronous reset
module ro_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/ro_sampler.sv
// rtl/ro_sampler.sv - RO TRNG receive side: sync, select, strobe sample, pack words, count drops
// Define RO_SAMPLER_VON_NEUMANN_EN to debias sample pairs before packing.
module ro_sampler
  import ro_trng_pkg::*;
#(
  parameter int NUM_RO      = RO_NUM_DEFAULT,
  parameter int SEL_W       = RO_SEL_W_DEFAULT,
  parameter int WORD_W      = 32,
  parameter int SAMPLE_DIV  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ro_enable,
  input  logic [NUM_RO-1:0]            ro_out,
  input  logic [SEL_W-1:0]             sel,
  output logic [WORD_W-1:0]            rnd_data,
  output logic                         rnd_valid,
  input  logic                         rnd_ready,
  output logic [$clog2(WORD_W+1)-1:0]  bit_count,
  output logic [DROP_CNT_W-1:0]        drop_cnt
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [NUM_RO-1:0] sync;
  logic              raw;
  logic [DIV_W-1:0]  div_cnt;
  logic              strobe;
  logic              acc_valid;
  logic              acc_bit;
  logic [WORD_W-2:0] shreg;
  logic [WORD_W-1:0] shifted;
  logic              full;
  logic              slot_free;
  ro_state_e         state;
  ro_state_e         state_nx;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
    ro_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (ro_out[i]),
      .q   (sync[i])
    );
  end

  // Out-of-range selects match no index and read as 0.
  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < NUM_RO; k++) begin
      if (sel == SEL_W'(k)) raw = sync[k];
    end
  end

  assign strobe = ro_enable && (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || !ro_enable || strobe) div_cnt <= '0;
    else                             div_cnt <= div_cnt + DIV_W'(1);
  end

`ifdef RO_SAMPLER_VON_NEUMANN_EN
  logic pair_flag;
  logic first_smp;

  always_ff @(posedge clk) begin
    if (rst || !ro_enable) begin
      pair_flag <= 1'b0;
      first_smp <= 1'b0;
    end else if (strobe) begin
      pair_flag <= ~pair_flag;
      if (!pair_flag) first_smp <= raw;
    end
  end

  // 10 yields 1 and 01 yields 0, so the emitted bit is the first sample.
  assign acc_valid = strobe && pair_flag && (first_smp != raw);
  assign acc_bit   = first_smp;
`else
  assign acc_valid = strobe;
  assign acc_bit   = raw;
`endif

  assign shifted   = {shreg, acc_bit};
  assign full      = (bit_count == LAST_BIT);
  assign slot_free = !rnd_valid || rnd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      bit_count <= '0;
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (rnd_valid && rnd_ready) rnd_valid <= 1'b0;
      if (acc_valid) begin
        if (!full) begin
          shreg     <= shifted[WORD_W-2:0];
          bit_count <= bit_count + CNT_W'(1);
        end else if (slot_free) begin
          rnd_data  <= shifted;
          rnd_valid <= 1'b1;
          bit_count <= '0;
        end else if (drop_cnt != '1) begin
          drop_cnt  <= drop_cnt + DROP_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!ro_enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    state_nx = COLLECT;
        COLLECT: if (full && rnd_valid && !rnd_ready) state_nx = STALL;
        STALL:   if (rnd_valid && rnd_ready) state_nx = COLLECT;
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
